// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// debounce FSM. The raw input is active-low and the outputs are active-high.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive stable
// synchronized samples. Accepted edges produce one-cycle press/release pulses
// and a wrapping 8-bit press counter.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  output logic       o_button,
  output logic       o_press,
  output logic       o_release,
  output logic [7:0] o_press_cnt
);

  // Elaboration-time guards on the parameter ranges.
  if (DEBOUNCE_CYCLES < 2) begin : gen_bad_cycles
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'(DEBOUNCE_CYCLES) - 64'd1) >= (64'd1 << CNT_W)) begin : gen_bad_width
    $error("button_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  // Terminal count: the counter value reached after DEBOUNCE_CYCLES stable samples.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } state_e;

  logic             s1_q, s2_q;
  logic             pressed;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q, button_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  // Two-flop synchronizer. Both flops reset to the idle level (released).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= i_button;
      s2_q <= s1_q;
    end
  end

  // Convert the synchronized active-low button into an active-high sample.
  assign pressed = ~s2_q;

  // Debounce FSM next state and counter. The counter restarts on every entry
  // to a wait state, so any bounce back to the old level discards progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pressed) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!pressed) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!pressed) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (pressed) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-state decode. Pulses are keyed on the accepting transitions only.
  always_comb begin
    button_d    = (state_d == StHeld) || (state_d == StReleaseWait);
    press_d     = (state_q == StPressWait) && (state_d == StHeld);
    release_d   = (state_q == StReleaseWait) && (state_d == StIdle);
    press_cnt_d = press_cnt_q;
    if (press_d) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      button_q    <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      button_q    <= button_d;
      press_q     <= press_d;
      release_q   <= release_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign o_button    = button_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_press_cnt = press_cnt_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3.
// Expected output snapshots are queued as stimulus is applied and popped when
// the corresponding DUT cycle is sampled.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b1;
  logic       o_button;
  logic       o_press;
  logic       o_release;
  logic [7:0] o_press_cnt;

  int checks = 0;
  int failures = 0;
  int press_seen = 0;
  int release_seen = 0;
  int ps;
  int rs;
  logic [7:0] model_cnt;

  typedef struct {
    string      tag;
    logic       button;
    logic       press;
    logic       rel;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_button   (btn),
    .o_button   (o_button),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_press_cnt(o_press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic b, input logic p, input logic r);
    exp_t e;
    e.tag    = tag;
    e.button = b;
    e.press  = p;
    e.rel    = r;
    e.cnt    = model_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".button"}, 32'(o_button), 32'(e.button));
    check({e.tag, ".press"}, 32'(o_press), 32'(e.press));
    check({e.tag, ".release"}, 32'(o_release), 32'(e.rel));
    check({e.tag, ".press_cnt"}, 32'(o_press_cnt), 32'(e.cnt));
  endtask

  // Sample 2 time units after the rising edge; the pulse monitor samples at 1.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    btn = v;
  endtask

  // Pulse monitor: counts pulses and flags simultaneous press/release.
  always @(posedge clk) begin
    #1;
    if (o_press) press_seen++;
    if (o_release) release_seen++;
    if (o_press || o_release) check("press_release_exclusive", 32'(o_press & o_release), 32'd0);
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_cnt = 8'd0;
    // Reset before any clock edge, then held across edges.
    #2;
    push("reset_async", 0, 0, 0); pop_check();
    tick(3);
    push("reset_held", 0, 0, 0); pop_check();
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset with button released.
    for (int i = 0; i < 10; i++) begin
      tick(10);
      push("idle", 0, 0, 0); pop_check();
    end
    check("idle_no_pulses", 32'(press_seen + release_seen), 32'd0);

    // Clean press: accepted after edge N+6.
    drive(0);
    push("press_n5", 0, 0, 0); tick(6); pop_check();
    model_cnt++;
    push("press_n6", 1, 1, 0); tick(1); pop_check();
    push("press_n7", 1, 0, 0); tick(1); pop_check();

    // Clean release, symmetric latency.
    drive(1);
    push("rel_n5", 1, 0, 0); tick(6); pop_check();
    push("rel_n6", 0, 0, 1); tick(1); pop_check();
    push("rel_n7", 0, 0, 0); tick(1); pop_check();

    // Glitch: low for three sampled edges only.
    ps = press_seen; rs = release_seen;
    drive(0);
    repeat (2) @(negedge clk);
    drive(1);
    tick(12);
    push("glitch", 0, 0, 0); pop_check();
    check("glitch_no_press", 32'(press_seen - ps), 32'd0);
    check("glitch_no_release", 32'(release_seen - rs), 32'd0);

    // Press again to reach HELD.
    drive(0);
    tick(7);
    model_cnt++;
    push("press2", 1, 1, 0); pop_check();
    tick(3);

    // Bouncy release: 1,0,1,0 then steady 1; release 6 edges after final rise.
    ps = press_seen; rs = release_seen;
    drive(1); drive(0); drive(1); drive(0); drive(1);
    push("bounce_m5", 1, 0, 0); tick(6); pop_check();
    push("bounce_m6", 0, 0, 1); tick(1); pop_check();
    tick(1);
    check("bounce_one_release", 32'(release_seen - rs), 32'd1);
    check("bounce_no_press", 32'(press_seen - ps), 32'd0);

    // Async reset between edges while in PRESS_WAIT with cnt=2.
    drive(0);
    tick(5);
    push("pw_before_rst", 0, 0, 0); pop_check();
    ps = press_seen;
    #2;
    rst_n = 1'b0;
    #1;
    model_cnt = 8'd0;
    push("rst_mid_debounce", 0, 0, 0); pop_check();
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    push("post_rst_n5", 0, 0, 0); tick(6); pop_check();
    model_cnt++;
    push("post_rst_n6", 1, 1, 0); tick(1); pop_check();
    check("post_rst_one_press", 32'(press_seen - ps), 32'd1);

    // Reset while HELD: discard state, no pulse during or after reset.
    tick(3);
    ps = press_seen; rs = release_seen;
    #1;
    rst_n = 1'b0;
    #1;
    model_cnt = 8'd0;
    push("rst_held", 0, 0, 0); pop_check();
    btn = 1'b1;
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(10);
    push("after_rst_held", 0, 0, 0); pop_check();
    check("rst_held_no_pulses", 32'((press_seen - ps) + (release_seen - rs)), 32'd0);

    // Wrap: 256 clean press/release cycles.
    ps = press_seen; rs = release_seen;
    for (int i = 0; i < 256; i++) begin
      drive(0);
      tick(8);
      drive(1);
      tick(8);
      model_cnt++;
      if (i == 254) begin
        push("wrap_ff", 0, 0, 0); pop_check();
      end
    end
    push("wrap_00", 0, 0, 0); pop_check();
    check("wrap_press_pulses", 32'(press_seen - ps), 32'd256);
    check("wrap_release_pulses", 32'(release_seen - rs), 32'd256);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
